// File: rtl/piece_bag_scheduler.sv
// 7-bag piece scheduler: filters LFSR shape codes through a bag mask into a preview FIFO
// and hands the head piece to the game FSM, forcing a pick when the generator stalls.
module piece_bag_scheduler #(
   parameter int DEPTH     = 3,
   parameter int MAX_RETRY = 15
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 New_Game,
   input  logic [2:0]           Rng_In,
   output logic                 Rng_Step,
   input  logic                 Piece_Req,
   output logic                 Piece_Valid,
   output logic [2:0]           Piece_Out,
   output logic [3*DEPTH-1:0]   Preview_Out,
   output logic [2:0]           Count,
   output logic [6:0]           Bag_Mask
);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL} fill_state_t;

   logic [2:0]  fifo      [DEPTH];
   logic [2:0]  next_fifo [DEPTH];
   logic [2:0]  count_q, count_d;
   logic [6:0]  mask_q, mask_d;
   logic [3:0]  retry_q, retry_d;
   fill_state_t state;

   logic        pop, fill, accept, forced, push;
   logic [2:0]  push_shape, fallback_shape, push_idx;
   logic [6:0]  rng_onehot, push_onehot, mask_set;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) fifo[i] <= 3'd0;
         count_q <= 3'd0;
         mask_q  <= 7'd0;
         retry_q <= 4'd0;
      end else begin
         for (int i = 0; i < DEPTH; i++) fifo[i] <= next_fifo[i];
         count_q <= count_d;
         mask_q  <= mask_d;
         retry_q <= retry_d;
      end
   end

   always_comb begin
      if (count_q == 3'd0)
         state = EMPTY;
      else if (count_q < 3'(DEPTH))
         state = FILLING;
      else
         state = FULL;
   end

   // The fallback scans from shape 7 down so the lowest clear shape wins.
   always_comb begin
      pop        = Piece_Req && (state != EMPTY);
      fill       = (state != FULL) || pop;
      Rng_Step   = fill && !New_Game;
      rng_onehot = (Rng_In == 3'd0) ? 7'd0 : (7'd1 << (Rng_In - 3'd1));
      accept     = (Rng_In != 3'd0) && ((mask_q & rng_onehot) == 7'd0);
      fallback_shape = 3'd1;
      for (int k = 6; k >= 0; k--) begin
         if (!mask_q[k]) fallback_shape = 3'(k + 1);
      end
      forced     = (retry_q == 4'(MAX_RETRY));
      push       = fill && (forced || accept);
      push_shape = forced ? fallback_shape : Rng_In;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) next_fifo[i] = fifo[i];
      mask_d      = mask_q;
      retry_d     = retry_q;
      push_onehot = 7'd1 << (push_shape - 3'd1);
      mask_set    = mask_q | push_onehot;
      push_idx    = pop ? (count_q - 3'd1) : count_q;

      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) next_fifo[i] = fifo[i + 1];
         next_fifo[DEPTH - 1] = 3'd0;
      end

      // A completed bag clears on the same edge so the next sample starts fresh.
      if (push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) == push_idx) next_fifo[i] = push_shape;
         end
         mask_d  = (mask_set == 7'h7F) ? 7'd0 : mask_set;
         retry_d = 4'd0;
      end else if (fill) begin
         retry_d = retry_q + 4'd1;
      end

      count_d = count_q + {2'd0, push} - {2'd0, pop};

      if (New_Game) begin
         for (int i = 0; i < DEPTH; i++) next_fifo[i] = 3'd0;
         count_d = 3'd0;
         mask_d  = 7'd0;
         retry_d = 4'd0;
      end
   end

   always_comb begin
      Count       = count_q;
      Bag_Mask    = mask_q;
      Piece_Valid = (state != EMPTY);
      Piece_Out   = fifo[0];
      Preview_Out = '0;
      for (int i = 0; i < DEPTH; i++) Preview_Out[3*i +: 3] = fifo[i];
   end

endmodule

// File: tb/tb_piece_bag_scheduler.sv
// Scoreboard bench for piece_bag_scheduler: stimulus queues expected snapshots and pieces,
// independent monitors pop and compare them against the DUT.
module tb_piece_bag_scheduler;

   localparam int DEPTH = 3;

   typedef struct {
      int         cycle;
      string      name;
      logic [2:0] count;
      logic [2:0] piece;
      logic [8:0] preview;
      logic [6:0] mask;
      int         step;
   } snap_t;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       newGame = 1'b0;
   logic [2:0] rngIn = 3'd0;
   logic       pieceReq = 1'b0;
   logic       rngStep;
   logic       pieceValid;
   logic [2:0] pieceOut;
   logic [8:0] previewOut;
   logic [2:0] count;
   logic [6:0] bagMask;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   snap_t      snapQ[$];
   snap_t      asyncQ[$];
   logic [2:0] pieceQ[$];
   event       resetDropped;

   piece_bag_scheduler #(.DEPTH(DEPTH), .MAX_RETRY(15)) dut (
      .Clk(clk), .Reset_n(resetN), .New_Game(newGame), .Rng_In(rngIn),
      .Rng_Step(rngStep), .Piece_Req(pieceReq), .Piece_Valid(pieceValid),
      .Piece_Out(pieceOut), .Preview_Out(previewOut), .Count(count), .Bag_Mask(bagMask)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic applyStimulus(input logic ng, input logic [2:0] rng, input logic req);
      @(negedge clk);
      newGame  = ng;
      rngIn    = rng;
      pieceReq = req;
   endtask

   task automatic expectSnap(input string name, input logic [2:0] c, input logic [2:0] p,
                             input logic [8:0] pv, input logic [6:0] m, input int st);
      snap_t e;
      e.cycle = cyc + 1; e.name = name; e.count = c; e.piece = p;
      e.preview = pv; e.mask = m; e.step = st;
      snapQ.push_back(e);
   endtask

   task automatic checkOutput(input snap_t e, input int nowCycle);
      logic ok;
      checks++;
      ok = (count == e.count) && (pieceValid == (e.count != 3'd0)) && (pieceOut == e.piece)
           && (previewOut == e.preview) && (bagMask == e.mask)
           && (e.step < 0 || rngStep == e.step[0]) && (e.cycle == nowCycle);
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d/%0d count=%0d/%0d valid=%0b piece=%0d/%0d preview=%h/%h mask=%h/%h step=%0b/%0d",
                  e.name, nowCycle, e.cycle, count, e.count, pieceValid, pieceOut, e.piece,
                  previewOut, e.preview, bagMask, e.mask, rngStep, e.step);
      end
   endtask

   // Snapshot monitor: compares state just after each rising edge.
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         while (snapQ.size() > 0 && snapQ[0].cycle <= cyc) begin
            e = snapQ.pop_front();
            checkOutput(e, cyc);
         end
      end
   end

   // Piece monitor: every accepted request must hand out the next expected piece.
   initial begin
      logic [2:0] expPiece;
      forever begin
         @(negedge clk);
         #2;
         if (resetN && !newGame && pieceReq && pieceValid) begin
            checks++;
            if (pieceQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_pop got=%0d expected=none", pieceOut);
            end else begin
               expPiece = pieceQ.pop_front();
               if (pieceOut !== expPiece) begin
                  errors++;
                  $display("[TB] FAIL piece_order got=%0d expected=%0d", pieceOut, expPiece);
               end
            end
         end
      end
   end

   initial begin
      snap_t e;
      forever begin
         @(resetDropped);
         #1;
         while (asyncQ.size() > 0) begin
            e = asyncQ.pop_front();
            e.cycle = cyc;
            checkOutput(e, cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired got=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      snap_t a;

      applyStimulus(0, 3'd0, 0);
      expectSnap("reset_hold", 3'd0, 3'd0, 9'o000, 7'h00, -1);

      // Fill from reset release: 3, 5, 1.
      applyStimulus(0, 3'd3, 0); resetN = 1'b1;
      expectSnap("fill_1", 3'd1, 3'd3, 9'o003, 7'h04, 1);
      applyStimulus(0, 3'd5, 0);
      expectSnap("fill_2", 3'd2, 3'd3, 9'o053, 7'h14, 1);
      applyStimulus(0, 3'd1, 0);
      expectSnap("fill_3", 3'd3, 3'd3, 9'o153, 7'h15, 0);
      applyStimulus(0, 3'd2, 0);
      expectSnap("full_hold", 3'd3, 3'd3, 9'o153, 7'h15, 0);

      // Bag rejection with an empty FIFO and shape 3 already drawn.
      applyStimulus(1, 3'd0, 0);
      expectSnap("ng_clear_a", 3'd0, 3'd0, 9'o000, 7'h00, 0);
      applyStimulus(0, 3'd3, 0);
      expectSnap("rej_seed", 3'd1, 3'd3, 9'o003, 7'h04, 1);
      applyStimulus(0, 3'd3, 1); pieceQ.push_back(3'd3);
      expectSnap("rej_pop", 3'd0, 3'd0, 9'o000, 7'h04, 1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 3'd3, 0);
         expectSnap("rej_dup", 3'd0, 3'd0, 9'o000, 7'h04, 1);
      end
      applyStimulus(0, 3'd6, 0);
      expectSnap("rej_accept6", 3'd1, 3'd6, 9'o006, 7'h24, 1);

      // Retry counter restarted at the push of 6: fallback lands 16 samples later.
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(0, 3'd0, 0);
         if (i < 16) expectSnap("retry_wait", 3'd1, 3'd6, 9'o006, 7'h24, 1);
         else        expectSnap("retry_fallback", 3'd2, 3'd6, 9'o016, 7'h25, 1);
      end

      // Fallback from a cleared bag.
      applyStimulus(1, 3'd0, 0);
      expectSnap("ng_clear_b", 3'd0, 3'd0, 9'o000, 7'h00, 0);
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(0, 3'd0, 0);
         if (i < 16) expectSnap("fb_wait", 3'd0, 3'd0, 9'o000, 7'h00, 1);
         else        expectSnap("fb_push1", 3'd1, 3'd1, 9'o001, 7'h01, 1);
      end

      // Bag rollover with continuous requests.
      applyStimulus(1, 3'd0, 0);
      expectSnap("ng_clear_c", 3'd0, 3'd0, 9'o000, 7'h00, 0);
      begin
         logic [2:0] seq [8]   = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7};
         logic [6:0] masks [8] = '{7'h40, 7'h60, 7'h70, 7'h78, 7'h7C, 7'h7E, 7'h00, 7'h40};
         for (int i = 0; i < 8; i++) begin
            applyStimulus(0, seq[i], 1);
            if (i > 0) pieceQ.push_back(seq[i-1]);
            expectSnap("rollover", 3'd1, seq[i], {6'd0, seq[i]}, masks[i], 1);
         end
         applyStimulus(0, 3'd0, 1); pieceQ.push_back(3'd7);
         expectSnap("rollover_drain", 3'd0, 3'd0, 9'o000, 7'h40, 1);
      end

      // Pop and push together while FULL.
      applyStimulus(1, 3'd0, 0);
      expectSnap("ng_clear_d", 3'd0, 3'd0, 9'o000, 7'h00, 0);
      applyStimulus(0, 3'd2, 0);
      expectSnap("full_2", 3'd1, 3'd2, 9'o002, 7'h02, 1);
      applyStimulus(0, 3'd4, 0);
      expectSnap("full_4", 3'd2, 3'd2, 9'o042, 7'h0A, 1);
      applyStimulus(0, 3'd6, 0);
      expectSnap("full_6", 3'd3, 3'd2, 9'o642, 7'h2A, 0);
      applyStimulus(0, 3'd1, 1); pieceQ.push_back(3'd2);
      expectSnap("full_poppush", 3'd3, 3'd4, 9'o164, 7'h2B, 1);
      applyStimulus(0, 3'd3, 0);
      expectSnap("full_idle", 3'd3, 3'd4, 9'o164, 7'h2B, 0);

      // New_Game beats a simultaneous request and an acceptable sample.
      applyStimulus(1, 3'd3, 1);
      expectSnap("ng_priority", 3'd0, 3'd0, 9'o000, 7'h00, 0);
      applyStimulus(0, 3'd5, 0);
      expectSnap("pre_reset_5", 3'd1, 3'd5, 9'o005, 7'h10, 1);
      applyStimulus(0, 3'd2, 0);
      expectSnap("pre_reset_2", 3'd2, 3'd5, 9'o025, 7'h12, 1);

      @(posedge clk);
      #3;
      a.cycle = 0; a.name = "async_reset"; a.count = 3'd0; a.piece = 3'd0;
      a.preview = 9'o000; a.mask = 7'h00; a.step = -1;
      asyncQ.push_back(a);
      resetN = 1'b0;
      -> resetDropped;

      applyStimulus(0, 3'd4, 0);
      expectSnap("reset_held", 3'd0, 3'd0, 9'o000, 7'h00, -1);
      applyStimulus(0, 3'd4, 0); resetN = 1'b1;
      expectSnap("post_reset_4", 3'd1, 3'd4, 9'o004, 7'h08, 1);

      applyStimulus(0, 3'd0, 0);
      applyStimulus(0, 3'd0, 0);
      @(posedge clk);
      #3;

      checks++;
      if (snapQ.size() != 0 || asyncQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL snapshot_drain left=%0d expected=0", snapQ.size() + asyncQ.size());
      end
      checks++;
      if (pieceQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL piece_drain left=%0d expected=0", pieceQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/piece_bag_scheduler.md
Name: piece_bag_scheduler

Overview:
- Controller between the 16-bit LFSR piece generator and the game FSM.
- Samples the generator's 3-bit shape codes (1..7) and applies a 7-bag rule: each bag yields every shape exactly once.
- Buffers accepted shapes in a preview FIFO.
- Hands pieces to the game FSM on request, with a deterministic fallback so a biased or stuck generator can never stall the game.

Parameters:
- DEPTH, 3, preview FIFO entries (1..7); entry 0 is the current head.
- MAX_RETRY, 15, consecutive rejected samples before a forced fallback pick (1..15, fits a 4-bit counter).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- New_Game  in  1  synchronous clear of FIFO, bag mask and retry counter.
- Rng_In  in  3  shape code from the LFSR generator; 0 is an invalid code.
- Rng_Step  out  1  advance enable for an enable-gated generator; combinational.
- Piece_Req  in  1  game FSM consumes the head piece this cycle.
- Piece_Valid  out  1  head entry holds a valid shape.
- Piece_Out  out  3  head shape; 0 when not valid.
- Preview_Out  out  3*DEPTH  entry i at bits [3i+2:3i]; invalid entries read 0.
- Count  out  3  number of valid FIFO entries (0..DEPTH).
- Bag_Mask  out  7  bit k-1 set means shape k has already been drawn from the current bag.

Behaviour:
- Reset (Reset_n=0, asynchronous): Count=0, Bag_Mask=0, retry counter=0, all FIFO entries=0. Outputs follow: Piece_Valid=0, Piece_Out=0, Preview_Out=0.
- New_Game=1: same clear on the next edge. It has priority over push and pop in that cycle.
- States (derived from Count): EMPTY (Count=0), FILLING (0<Count<DEPTH), FULL (Count=DEPTH).
- Fill condition: fill = (Count<DEPTH) or pop; Rng_Step = fill and not New_Game.
- Pop: pop = Piece_Req and Piece_Valid. Piece_Req while EMPTY is ignored and not remembered. On pop, entries shift toward the head by one.
- Sample each cycle fill=1:
  - Accept if Rng_In≠0 and the Bag_Mask bit for Rng_In is clear.
  - Reject otherwise: no push, retry counter +1.
- Fallback: if the retry counter equals MAX_RETRY, the current cycle pushes the lowest-numbered shape whose mask bit is clear, regardless of Rng_In.
- Any push clears the retry counter to 0.
- Retry counter holds its value while fill=0.
- On push of shape v:
  - Set mask bit v-1.
  - If the mask becomes 7'h7F, clear it to 0 on the same edge, so the next sample starts a fresh bag.
- Push target:
  - Entry Count, without a simultaneous pop.
  - Entry Count-1, with a simultaneous pop.
- Count arithmetic: next Count = Count + push − pop. Never exceeds DEPTH, never goes below 0.
- Simultaneous pop and push in the FULL state: Count stays DEPTH.
- Latency:
  - Accepted sample appears in the FIFO on the next edge.
  - From reset release, the earliest Piece_Valid=1 is after the first edge.
  - After a pop from FULL, the refilled tail entry is valid after that same edge if the sample was accepted.
- Bag integrity: any 7 consecutive pushes starting from a cleared mask contain each of 1..7 exactly once. This holds with fallback and across pops.
- Asserting Reset_n mid-fill discards all partial bag state; there is no recovery of the prior bag.

Test Plan:
- Reset/fill: release Reset_n with Rng_In sequence 3,5,1, no requests → Count=1,2,3 on consecutive edges; Preview_Out={1,5,3} (entry0=3); Piece_Valid=1; Rng_Step=0 once FULL.
- Bag rejection: FIFO empty, mask=7'b0000100 (shape 3 drawn), drive Rng_In=3 for 2 cycles then 6 → two rejects, then 6 pushed; mask=7'b0100100; retry counter returns to 0.
- Fallback: hold Rng_In=0 for 15 cycles with mask=0 and Count=0 → no push for 15 cycles; on the 16th edge shape 1 is pushed; Count=1.
- Bag rollover: feed 7,6,5,4,3,2,1 with continuous Piece_Req → pieces out 7,6,5,4,3,2,1; mask reads 0 after the 7th push; next Rng_In=7 is accepted.
- Pop+push at FULL: DEPTH=3 holding {2,4,6}, Piece_Req=1, Rng_In=1 → Piece_Out becomes 4; Preview_Out entries {4,6,1}; Count stays 3.
- Clears: assert New_Game together with Piece_Req and an acceptable Rng_In → next edge Count=0, mask=0, Piece_Out=0. Drop Reset_n mid-cycle → outputs go 0 immediately, without waiting for Clk.
